// File: rtl/cordic_engine.sv
// Iterative CORDIC engine: rotation (cos/sin) and vectoring (magnitude/atan2) with quadrant correction.
// Define CORDIC_GAIN_COMP_EN to add a COMP state that scales the vectoring magnitude by 1/K.
module cordic_engine #(
    parameter int WIDTH = 16,
    parameter int ITER  = 14,
    parameter int GUARD = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_z,
    output logic             out_mode
);
    // One extra integer bit above the port format absorbs the K ~ 1.647 growth and +-pi overshoot.
    localparam int  IW   = WIDTH + GUARD + 1;
    localparam int  CW   = $clog2(ITER);
    localparam int  FXY  = WIDTH - 2 + GUARD;
    localparam int  FZ   = WIDTH - 3 + GUARD;
    localparam real PI_R = 3.14159265358979323846;
    localparam real INVK = 0.6072529350088813;

    localparam logic signed [IW-1:0] PI_Q      = IW'($rtoi(PI_R * (2.0 ** FZ) + 0.5));
    localparam logic signed [IW-1:0] HALF_PI_Q = IW'($rtoi(PI_R / 2.0 * (2.0 ** FZ) + 0.5));
    localparam logic signed [IW-1:0] INV_K_Q   = IW'($rtoi(INVK * (2.0 ** FXY) + 0.5));
    localparam logic signed [IW-1:0] MAG_MAX   = IW'((1 << (WIDTH - 1)) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
`ifdef CORDIC_GAIN_COMP_EN
        , S_COMP
`endif
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic signed [IW-1:0] x, y, z;
    logic                 mode, neg, zero;
    logic signed [IW-1:0] ld_x, ld_y, ld_z, zi;
    logic                 ld_neg, ld_zero;
    logic signed [IW-1:0] xs, ys, at, x_n, y_n, z_n;
    logic                 d_pos, last, to_comp;
    logic [WIDTH-1:0]     res_x, res_y, res_z;

    // atan(2^-i) table carries the guard bits so the angle path keeps the same precision as x/y.
    logic signed [IW-1:0] atan_tab [ITER];
    for (genvar i = 0; i < ITER; i++) begin : g_atan
        assign atan_tab[i] = IW'($rtoi($atan(2.0 ** (-i)) * (2.0 ** FZ) + 0.5));
    end

    function automatic logic signed [IW-1:0] widen(input logic [WIDTH-1:0] v);
        return {v[WIDTH-1], v, {GUARD{1'b0}}};
    endfunction

    function automatic logic [WIDTH-1:0] trunc(input logic signed [IW-1:0] v);
        return WIDTH'(v >>> GUARD);
    endfunction

    function automatic logic [WIDTH-1:0] sat_mag(input logic signed [IW-1:0] v);
        logic signed [IW-1:0] t;
        t = v >>> GUARD;
        return (t > MAG_MAX) ? MAG_MAX[WIDTH-1:0] : WIDTH'(t);
    endfunction

    assign in_ready = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign last = (cnt == CW'(ITER - 1));
`ifdef CORDIC_GAIN_COMP_EN
    assign to_comp = mode;
`else
    assign to_comp = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_valid) state_nxt = S_ITER;
            S_ITER: if (last) state_nxt = to_comp ? state_t'(S_DONE + 2'd1) : S_DONE;
`ifdef CORDIC_GAIN_COMP_EN
            S_COMP: state_nxt = S_DONE;
`endif
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Rotation angles beyond +-pi/2 are folded by pi and the result negated afterwards.
    always_comb begin
        zi      = widen(in_z);
        ld_x    = INV_K_Q;
        ld_y    = '0;
        ld_z    = zi;
        ld_neg  = 1'b0;
        ld_zero = (in_x == '0) && (in_y == '0);
        if (in_mode) begin
            if (in_x[WIDTH-1]) begin
                ld_x = -widen(in_x);
                ld_y = -widen(in_y);
                ld_z = in_y[WIDTH-1] ? -PI_Q : PI_Q;
            end else begin
                ld_x = widen(in_x);
                ld_y = widen(in_y);
                ld_z = '0;
            end
        end else if (zi > HALF_PI_Q) begin
            ld_z   = zi - PI_Q;
            ld_neg = 1'b1;
        end else if (zi < -HALF_PI_Q) begin
            ld_z   = zi + PI_Q;
            ld_neg = 1'b1;
        end
    end

    always_comb begin
        d_pos = mode ? y[IW-1] : ~z[IW-1];
        xs    = x >>> cnt;
        ys    = y >>> cnt;
        at    = atan_tab[cnt];
        x_n   = d_pos ? x - ys : x + ys;
        y_n   = d_pos ? y + xs : y - xs;
        z_n   = d_pos ? z - at : z + at;
        res_x = mode ? sat_mag(x_n) : trunc(neg ? -x_n : x_n);
        res_y = trunc(neg ? -y_n : y_n);
        res_z = zero ? '0 : trunc(z_n);
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam int WP1 = WIDTH + 1;
    localparam int PW  = IW + WIDTH + 1;
    localparam logic signed [PW-1:0] INV_K_OUT = PW'($rtoi(INVK * (2.0 ** (WIDTH - 2)) + 0.5));
    localparam logic signed [PW-1:0] RND       = PW'(2 ** (FXY - 1));
    logic signed [PW-1:0] prod, prod_r;
    logic [WIDTH-1:0]     comp_x;
    always_comb begin
        prod   = PW'(x) * INV_K_OUT;
        prod_r = (prod + RND) >>> FXY;
        comp_x = (prod_r > PW'(MAG_MAX)) ? MAG_MAX[WIDTH-1:0] : WIDTH'(prod_r);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            x        <= '0;
            y        <= '0;
            z        <= '0;
            mode     <= 1'b0;
            neg      <= 1'b0;
            zero     <= 1'b0;
            out_x    <= '0;
            out_y    <= '0;
            out_z    <= '0;
            out_mode <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (in_valid) begin
                    x    <= ld_x;
                    y    <= ld_y;
                    z    <= ld_z;
                    mode <= in_mode;
                    neg  <= ld_neg & ~in_mode;
                    zero <= ld_zero & in_mode;
                    cnt  <= '0;
                end
                S_ITER: begin
                    x   <= x_n;
                    y   <= y_n;
                    z   <= z_n;
                    cnt <= cnt + CW'(1);
                    if (last && !to_comp) begin
                        out_x    <= res_x;
                        out_y    <= res_y;
                        out_z    <= res_z;
                        out_mode <= mode;
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                S_COMP: begin
                    out_x    <= comp_x;
                    out_y    <= trunc(y);
                    out_z    <= zero ? '0 : trunc(z);
                    out_mode <= mode;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_engine.sv
// Self-checking bench for cordic_engine: directed literal cases plus randomized ops against a real-math model.
module tb_cordic_engine;
    localparam int W  = 16;
    localparam int IT = 14;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int VLAT = IT + 1;
`else
    localparam int VLAT = IT;
`endif

    typedef struct {
        bit mode;
        int x, y, z;
        int tx, ty, tz;
        int lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_mode, out_ready;
    logic [W-1:0] in_x, in_y, in_z;
    logic         in_ready, out_valid, out_mode;
    logic [W-1:0] out_x, out_y, out_z;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    real  kn;
    bit   rdone;
    exp_t me, ce;
    int   ca;
    bit   pv = 1'b0;
    int   hx, hy, hz, hm;
    bit   rm;
    int   rx, ry, rz, n;

    cordic_engine #(.WIDTH(W), .ITER(IT), .GUARD(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_mode(out_mode)
    );

    always #5 clk = ~clk;

    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic chk(input string nm, input int act, input int expv, input int tol);
        checks++;
        if (act - expv > tol || expv - act > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", nm, act, expv, tol);
        end
    endtask

    // Ideal real-valued result; rotation residual angle and vectoring residual y are expected near 0.
    function automatic exp_t model(input bit m, input int x, input int y, input int z, input int tol);
        exp_t e;
        real  mag;
        e.mode = m;
        e.tx = tol; e.ty = tol; e.tz = tol;
        if (!m) begin
            e.x = int'($cos(z / 8192.0) * 16384.0);
            e.y = int'($sin(z / 8192.0) * 16384.0);
            e.z = 0;
            e.tz = 4;
            e.lat = IT;
        end else begin
            mag = $sqrt(real'(x * x + y * y));
`ifndef CORDIC_GAIN_COMP_EN
            mag = mag * kn;
`endif
            e.x = (mag > 32767.0) ? 32767 : int'(mag);
            e.y = 0;
            e.ty = 8;
            e.z = int'($atan2(real'(y), real'(x)) * 8192.0);
            e.lat = VLAT;
        end
        return e;
    endfunction

    function automatic exp_t lit(input bit m, input int x, input int y, input int z, input int lat);
        exp_t e;
        e.mode = m; e.x = x; e.y = y; e.z = z; e.lat = lat;
        e.tx = 4; e.ty = m ? 8 : 4; e.tz = 4;
        return e;
    endfunction

    task automatic send(input exp_t e, input bit m, input int x, input int y, input int z);
        int k;
        @(negedge clk);
        in_valid = 1'b1; in_mode = m;
        in_x = x[W-1:0]; in_y = y[W-1:0]; in_z = z[W-1:0];
        exp_q.push_back(e);
        k = 0;
        while (!in_ready && k < 200) begin @(negedge clk); k++; end
        if (!in_ready) chk("accept_timeout", k, 0, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_x = W'($urandom); in_y = W'($urandom); in_z = W'($urandom); in_mode = 1'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 200) begin @(negedge clk); k++; end
        if (k >= 200) chk("idle_timeout", k, 0, 0);
    endtask

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
        cyc++;
    end

    // Single compare process: result on the rising cycle, then stability and in_ready while held.
    always @(negedge clk) begin
        if (!rst_n) pv = 1'b0;
        else begin
            if (out_valid && !pv) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) chk("unexpected_out_valid", 1, 0, 0);
                else begin
                    ce = exp_q.pop_front();
                    ca = acc_q.pop_front();
                    chk("latency", cyc - ca - 1, ce.lat, 0);
                    chk("out_mode", int'(out_mode), int'(ce.mode), 0);
                    chk("out_x", sx(out_x), ce.x, ce.tx);
                    chk("out_y", sx(out_y), ce.y, ce.ty);
                    chk("out_z", sx(out_z), ce.z, ce.tz);
                end
                hx = sx(out_x); hy = sx(out_y); hz = sx(out_z); hm = int'(out_mode);
            end else if (out_valid) begin
                chk("hold_x", sx(out_x), hx, 0);
                chk("hold_y", sx(out_y), hy, 0);
                chk("hold_z", sx(out_z), hz, 0);
                chk("hold_mode", int'(out_mode), hm, 0);
            end
            if (out_valid) chk("busy_in_ready", int'(in_ready), 0, 0);
            pv = out_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        kn = 1.0;
        for (int i = 0; i < IT; i++) kn = kn * $sqrt(1.0 + 2.0 ** (-2 * i));
        rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b1;
        in_x = '0; in_y = '0; in_z = '0;
        #2;
        chk("rst_out_valid", int'(out_valid), 0, 0);
        chk("rst_in_ready", int'(in_ready), 1, 0);
        chk("rst_out_x", sx(out_x), 0, 0);
        chk("rst_out_z", sx(out_z), 0, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        me = model(1'b0, 0, 0, 19302, 0);
        chk("model_rot_x", me.x, -11585, 1);
        chk("model_rot_y", me.y, 11585, 1);
        me = model(1'b1, 8192, 8192, 0, 0);
        chk("model_vec_z", me.z, 6434, 1);

        send(lit(0, 16384, 0, 0, IT), 0, 0, 0, 0);                 wait_idle();
        send(lit(0, 0, 16384, 0, IT), 0, 0, 0, 12868);             wait_idle();
        send(lit(0, -11585, 11585, 0, IT), 0, 0, 0, 19302);        wait_idle();
        send(lit(0, -11585, -11585, 0, IT), 0, 0, 0, -19302);      wait_idle();
`ifdef CORDIC_GAIN_COMP_EN
        send(lit(1, 11585, 0, 6434, VLAT), 1, 8192, 8192, 0);      wait_idle();
        send(lit(1, 8192, 0, 25736, VLAT), 1, -8192, 0, 0);        wait_idle();
        send(lit(1, 23170, 0, 6434, VLAT), 1, 16384, 16384, 0);    wait_idle();
`else
        send(lit(1, 19079, 0, 6434, VLAT), 1, 8192, 8192, 0);      wait_idle();
        send(lit(1, 13490, 0, 25736, VLAT), 1, -8192, 0, 0);       wait_idle();
        send(lit(1, 32767, 0, 6434, VLAT), 1, 16384, 16384, 0);    wait_idle();
`endif
        send(lit(1, 0, 0, 0, VLAT), 1, 0, 0, 0);                   wait_idle();

        // Backpressure: result held for 10 cycles while a second operand waits.
        out_ready = 1'b0;
        send(lit(0, 16384, 0, 0, IT), 0, 0, 0, 0);
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        chk("bp_valid_seen", int'(out_valid), 1, 0);
        fork
            send(model(1'b0, 0, 0, 8000, 6), 0, 0, 0, 8000);
            begin
                repeat (10) @(negedge clk);
                chk("bp_still_valid", int'(out_valid), 1, 0);
                chk("bp_in_ready_low", int'(in_ready), 0, 0);
                out_ready = 1'b1;
                @(negedge clk);
                chk("bp_valid_drop", int'(out_valid), 0, 0);
                chk("bp_in_ready_up", int'(in_ready), 1, 0);
            end
        join
        wait_idle();

        // Asynchronous reset at iteration 7, entirely between clock edges.
        send(lit(0, 0, 16384, 0, IT), 0, 0, 0, 12868);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0, 0);
        chk("arst_in_ready", int'(in_ready), 1, 0);
        chk("arst_out_x", sx(out_x), 0, 0);
        chk("arst_out_y", sx(out_y), 0, 0);
        chk("arst_out_z", sx(out_z), 0, 0);
        chk("arst_out_mode", int'(out_mode), 0, 0);
        exp_q.delete();
        acc_q.delete();
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("arst_no_pulse", int'(out_valid), 0, 0);
        send(lit(0, -11585, 11585, 0, IT), 0, 0, 0, 19302);        wait_idle();

        // Randomized mix with random consumer backpressure.
        rdone = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    rm = 1'($urandom_range(0, 1));
                    rz = 0; rx = 0; ry = 0;
                    if (rm) begin
                        do begin
                            rx = int'($urandom_range(0, 32768)) - 16384;
                            ry = int'($urandom_range(0, 32768)) - 16384;
                        end while (iabs(rx) < 2048 && iabs(ry) < 2048);
                    end else begin
                        rz = int'($urandom_range(0, 51472)) - 25736;
                    end
                    send(model(rm, rx, ry, rz, 6), rm, rx, ry, rz);
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
